shift_deserializer: RTL and testbench

//   Downstream counterpart of the masked share serializer. Accepts SHIFT_WIDTH-bit

---
 rtl/masked_shift_pkg.sv | 24 ++
 rtl/shift_deserializer.sv | 127 ++++++++++++
 tb/tb_shift_deserializer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/masked_shift_pkg.sv
// Shared definitions for the masked share serializer / deserializer pair:
// default masking parameters, slice-count helpers and the deserializer FSM states.
package masked_shift_pkg;

    localparam int DEFAULT_D   = 2;
    localparam int DEFAULT_PAR = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } deser_state_e;

    // Number of slices needed to cover a word, rounding up to whole slices.
    function automatic int num_slices(input int width, input int sw);
        return (width + sw - 1) / sw;
    endfunction

    // Word width rounded up to a whole number of slices.
    function automatic int padded_width(input int width, input int sw);
        return num_slices(width, sw) * sw;
    endfunction

endpackage

// File: rtl/shift_deserializer.sv
// shift_deserializer: collects SHIFT_WIDTH-bit slices (LSB slice first) into a
// WIDTH-bit masked word and presents it with a valid/ready handshake.
// Optional feature macro: SHIFT_DESER_FLUSH_EN adds a 'flush' input that emits a
// partial word right-aligned and zero-padded.
module shift_deserializer
    import masked_shift_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int PAR         = DEFAULT_PAR,
    parameter int d           = DEFAULT_D,
    parameter int SHIFT_WIDTH = (d + 1) * PAR
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
`ifdef SHIFT_DESER_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SHIFT_WIDTH-1:0] slice_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   busy
);

    localparam int PADDED_WIDTH = padded_width(WIDTH, SHIFT_WIDTH);
    localparam int NUM_SLICES   = num_slices(WIDTH, SHIFT_WIDTH);
    localparam int CNT_W        = $clog2(NUM_SLICES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    deser_state_e            r_state;
    deser_state_e            w_state_next;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_next;
    logic [PADDED_WIDTH-1:0] r_data;
    logic [PADDED_WIDTH-1:0] w_data_next;
    logic [PADDED_WIDTH-1:0] w_shift_in;
    logic                    w_accept;

    // New slices enter at the top, so the first slice ends up at bit 0.
    assign w_accept   = in_valid && (r_state != FULL);
    assign w_shift_in = {slice_in, r_data[PADDED_WIDTH-1:SHIFT_WIDTH]};

`ifdef SHIFT_DESER_FLUSH_EN
    logic [CNT_W-1:0]        w_fill;
    logic [PADDED_WIDTH-1:0] w_flush_base;
    logic [PADDED_WIDTH-1:0] w_flush_data;

    // Right-align a partial word: drop the slices that never arrived in one step.
    always_comb begin
        w_flush_base = w_accept ? w_shift_in : r_data;
        w_fill       = w_accept ? (r_count + CNT_W'(1)) : r_count;
        w_flush_data = w_flush_base;
        for (int k = 1; k < NUM_SLICES; k++) begin
            if (w_fill == CNT_W'(k)) begin
                w_flush_data = w_flush_base >> ((NUM_SLICES - k) * SHIFT_WIDTH);
            end
        end
    end
`endif

    // Next state, slice count and shift register contents.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_data_next  = r_data;
        if (clear) begin
            // Abort wins over everything; the register contents are left as-is.
            w_state_next = IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                IDLE, COLLECT: begin
                    if (w_accept) begin
                        w_data_next = w_shift_in;
                        if (r_count == LAST_CNT) begin
                            w_state_next = FULL;
                            w_count_next = '0;
                        end else begin
                            w_state_next = COLLECT;
                            w_count_next = r_count + CNT_W'(1);
                        end
                    end
`ifdef SHIFT_DESER_FLUSH_EN
                    // A slice that completes the word makes the flush redundant.
                    if (flush && (r_state == COLLECT) && (w_state_next != FULL)) begin
                        w_data_next  = w_flush_data;
                        w_state_next = FULL;
                        w_count_next = '0;
                    end
`endif
                end
                FULL: begin
                    // Register stays frozen; it is simply overwritten by the next word.
                    if (out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // State, count and data registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_data  <= w_data_next;
        end
    end

    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state == FULL);
    assign busy      = (r_state == COLLECT);
    assign data_out  = r_data[WIDTH-1:0];

endmodule

// File: tb/tb_shift_deserializer.sv
// Testbench for shift_deserializer (WIDTH=64, PAR=1, d=2). Stimulus pushes expected
// words into a queue; a monitor compares whenever out_valid is high.
// Flush tests run only when SHIFT_DESER_FLUSH_EN is defined.
module tb_shift_deserializer;

    localparam int W   = 64;
    localparam int SW  = 3;
    localparam int NUM = 22;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] slice_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  data_out;
    logic          busy;
`ifdef SHIFT_DESER_FLUSH_EN
    logic          flush;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_acc;
    int           m_cnt;
    bit           bp_rand  = 1'b0;
    logic         or_force = 1'b1;

    shift_deserializer #(.WIDTH(64), .PAR(1), .d(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
`ifdef SHIFT_DESER_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .slice_in  (slice_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Consumer: either random backpressure or a directed level.
    always @(negedge clk) begin
        out_ready = bp_rand ? 1'($urandom_range(0, 1)) : or_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: slice k of a word lands at bit k*SW, bits above W dropped.
    function automatic bit model_accept(input logic [SW-1:0] s);
        logic [127:0] t;
        t = 128'(s) << (m_cnt * SW);
        m_acc = m_acc | t[W-1:0];
        m_cnt++;
        if (m_cnt == NUM) begin
            exp_q.push_back(m_acc);
            m_acc = '0;
            m_cnt = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_acc = '0;
        m_cnt = 0;
    endfunction

    // Monitor: any presented word must match the oldest expected word.
    always @(negedge clk) begin
        #2;
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", data_out);
            end else begin
                check("word_data", data_out, exp_q[0]);
                check("in_ready_in_full", 64'(in_ready), 64'd0);
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [SW-1:0] s);
        int guard;
        bit done;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        slice_in = s;
        while (in_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        done = model_accept(s);
        #1;
        in_valid = 1'b0;
        if (done) check("out_valid_latency", 64'(out_valid), 64'd1);
        else      check("busy_collect", 64'(busy), 64'd1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        logic [65:0]   wide;
        logic [SW-1:0] rs;

        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        slice_in = '0;
`ifdef SHIFT_DESER_FLUSH_EN
        flush    = 1'b0;
`endif
        model_reset();
        #1;
        check_idle_outputs("reset");
        check("reset_data_out", data_out, 64'd0);
        #12;
        reset_n = 1'b1;

        // Loopback of a known word, LSB slice first.
        wide = 66'(64'h0123_4567_89AB_CDEF);
        for (int k = 0; k < NUM; k++) send(wide[k*SW +: SW]);
        drain();
        $display("INFO loopback word done checks=%0d", checks);

        // Backpressure: hold the word for several cycles, then release.
        or_force = 1'b0;
        for (int k = 0; k < NUM; k++) send(3'($urandom));
        repeat (5) begin
            @(negedge clk);
            #3;
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        or_force = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("after_handshake");
        for (int k = 0; k < NUM; k++) send(3'($urandom));
        drain();
        $display("INFO backpressure words done checks=%0d", checks);

        // Gapped input, constant slice pattern.
        for (int k = 0; k < NUM; k++) begin
            send(3'b101);
            @(negedge clk);
            #1;
            if (k < NUM - 1) check("gap_busy", 64'(busy), 64'd1);
        end
        drain();
        $display("INFO gapped word done checks=%0d", checks);

        // Abort a partial word with clear; the next word must carry no residue.
        for (int k = 0; k < 10; k++) send(3'($urandom));
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        #1;
        check_idle_outputs("after_clear");
        for (int k = 0; k < NUM; k++) send(3'b111);
        drain();
        $display("INFO clear test done checks=%0d", checks);

        // Asynchronous reset in the middle of a word.
        for (int k = 0; k < 7; k++) send(3'($urandom));
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_data_out", data_out, 64'd0);
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < NUM; k++) send(3'($urandom));
        drain();
        $display("INFO mid-word reset done checks=%0d", checks);

`ifdef SHIFT_DESER_FLUSH_EN
        // Flush a 4-slice partial word.
        for (int k = 0; k < 4; k++) send(3'b011);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        exp_q.push_back(m_acc);
        model_reset();
        #1;
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd1);
        drain();
        // Flush in IDLE is ignored.
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_idle_outputs("flush_in_idle");
        // Slice accepted in the flush cycle is included.
        for (int k = 0; k < 2; k++) send(3'($urandom));
        rs = 3'($urandom);
        @(negedge clk);
        in_valid = 1'b1;
        slice_in = rs;
        flush    = 1'b1;
        @(posedge clk);
        void'(model_accept(rs));
        exp_q.push_back(m_acc);
        model_reset();
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_out_valid", 64'(out_valid), 64'd1);
        drain();
        $display("INFO flush tests done checks=%0d", checks);
`endif

        // Randomized words with random gaps and random backpressure.
        bp_rand = 1'b1;
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < NUM; k++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send(3'($urandom));
            end
        end
        drain();
        bp_rand = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
